// File: rtl/ssd_pkg.sv
// Shared types and 7-segment glyph constants for the message scheduler.
// Segments are packed {g,f,e,d,c,b,a} and are active-low.
package ssd_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    MSG  = 1'b1
  } state_t;

  typedef logic [3:0][6:0] disp_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_I     = 7'h79;
  localparam logic [6:0] SEG_L     = 7'h47;

  localparam disp_t BLANK_DISP = {4{SEG_BLANK}};

  // Leftmost character sits in element [3].
  localparam disp_t MSG_TABLE [0:7] = '{
    {SEG_E,     SEG_R,     SEG_R,     SEG_BLANK},
    {SEG_G,     SEG_O,     SEG_O,     SEG_D},
    {SEG_F,     SEG_A,     SEG_I,     SEG_L},
    {SEG_DASH,  SEG_DASH,  SEG_DASH,  SEG_DASH},
    BLANK_DISP,
    BLANK_DISP,
    BLANK_DISP,
    BLANK_DISP
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment glyph; non-decimal codes show a dash.
module seg7_decode
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_msg_sched.sv
// Shows a live 4-digit BCD value, or a timed/blinking canned message on request.
// All outputs are registered from next-state values, so they follow inputs by one cycle.
module ssd_msg_sched
  import ssd_pkg::*;
#(
  parameter int CLK_PER_MS = 100000,
  parameter int BLINK_MS   = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][3:0] live_bcd,
  input  logic            msg_req,
  input  logic [2:0]      msg_id,
  input  logic [15:0]     msg_ms,
  input  logic            msg_blink,
  input  logic            msg_clr,
  output logic            msg_ack,
  output logic            msg_done,
  output logic [3:0][6:0] ssd_out
);

  localparam logic [19:0] PRESC_LAST = 20'(CLK_PER_MS - 1);
  localparam logic [9:0]  BLINK_LAST = 10'(BLINK_MS - 1);

  logic [19:0] presc;
  logic        ms_tick;

  state_t      state, state_n;
  logic [15:0] hold, hold_n;
  logic [2:0]  id_q, id_n;
  logic        blink_q, blink_n;
  logic        phase_on, phase_n;
  logic [9:0]  bcnt, bcnt_n;
  logic        ack_n, done_n;
  disp_t       live_seg, live_disp, disp_n;
  logic [3:1]  lead_zero;

  assign ms_tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst || ms_tick) presc <= '0;
    else                presc <= presc + 20'd1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dec
    seg7_decode u_dec (
      .bcd (live_bcd[i]),
      .seg (live_seg[i])
    );
  end

  // Leading zeros blank from the left; the units digit always shows.
  always_comb begin
    lead_zero[3] = (live_bcd[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (live_bcd[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (live_bcd[1] == 4'd0);
    live_disp[0] = live_seg[0];
    for (int i = 1; i < 4; i++)
      live_disp[i] = lead_zero[i] ? SEG_BLANK : live_seg[i];
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    id_n    = id_q;
    blink_n = blink_q;
    phase_n = phase_on;
    bcnt_n  = bcnt;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    if (msg_req) begin
      state_n = MSG;
      hold_n  = msg_ms;
      id_n    = msg_id;
      blink_n = msg_blink;
      phase_n = 1'b1;
      bcnt_n  = '0;
      ack_n   = 1'b1;
    end else if (state == MSG) begin
      if (msg_clr) begin
        state_n = LIVE;
        hold_n  = '0;
      end else if (ms_tick) begin
        // A zero hold never reaches here as a countdown: it means hold forever.
        if (hold == 16'd1) begin
          state_n = LIVE;
          hold_n  = '0;
          done_n  = 1'b1;
        end else if (hold != 16'd0) begin
          hold_n = hold - 16'd1;
        end
        if (blink_q) begin
          if (bcnt == BLINK_LAST) begin
            bcnt_n  = '0;
            phase_n = ~phase_on;
          end else begin
            bcnt_n = bcnt + 10'd1;
          end
        end
      end
    end
    if (state_n == MSG) disp_n = phase_n ? MSG_TABLE[id_n] : BLANK_DISP;
    else                disp_n = live_disp;
  end

  // Output stage boundary: state and display register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LIVE;
      hold     <= '0;
      id_q     <= '0;
      blink_q  <= 1'b0;
      phase_on <= 1'b1;
      bcnt     <= '0;
      msg_ack  <= 1'b0;
      msg_done <= 1'b0;
      ssd_out  <= BLANK_DISP;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      id_q     <= id_n;
      blink_q  <= blink_n;
      phase_on <= phase_n;
      bcnt     <= bcnt_n;
      msg_ack  <= ack_n;
      msg_done <= done_n;
      ssd_out  <= disp_n;
    end
  end

endmodule
